// File: rtl/nf_ahb_arb.sv
// AHB-Lite multi-master arbiter: grants one master the shared bus and stalls the rest.
// Define NF_AHB_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
`timescale 1ns/1ps
module nf_ahb_arb #(
    parameter int master_c = 2
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic [master_c-1:0][31:0] haddr_m,
    input  logic [master_c-1:0][31:0] hwdata_m,
    input  logic [master_c-1:0][0:0]  hwrite_m,
    input  logic [master_c-1:0][1:0]  htrans_m,
    input  logic [master_c-1:0][2:0]  hsize_m,
    input  logic [master_c-1:0][2:0]  hburst_m,
    output logic [master_c-1:0][31:0] hrdata_m,
    output logic [master_c-1:0][1:0]  hresp_m,
    output logic [master_c-1:0][0:0]  hready_m,
    output logic [31:0]               haddr,
    output logic [31:0]               hwdata,
    output logic [0:0]                hwrite,
    output logic [1:0]                htrans,
    output logic [2:0]                hsize,
    output logic [2:0]                hburst,
    input  logic [31:0]               hrdata,
    input  logic [1:0]                hresp,
    input  logic [0:0]                hready,
    output logic [master_c-1:0]       owner
);
    localparam int IW = (master_c > 1) ? $clog2(master_c) : 1;

    typedef enum logic {ARB = 1'b0, OWN = 1'b1} state_t;

    state_t              state_reg, state_next;
    logic [IW-1:0]       owner_idx_reg, owner_idx_next;
    logic [IW-1:0]       winner;
    logic [master_c-1:0] req;
    logic                any_req;

    genvar gi;
    generate
        for (gi = 0; gi < master_c; gi++) begin : g_master
            // BUSY is treated as a request so a master mid-burst keeps its claim.
            assign req[gi]      = (htrans_m[gi] != 2'b00);
            assign hrdata_m[gi] = hrdata;
            assign hready_m[gi] = owner[gi] ? hready : 1'b0;
            assign hresp_m[gi]  = owner[gi] ? hresp : 2'b00;
        end
    endgenerate

    assign any_req = |req;

`ifdef NF_AHB_ARB_RR_EN
    logic [IW-1:0] last_idx_reg;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= master_c) s = s - master_c;
        return IW'(s);
    endfunction

    // Scan from farthest to nearest so the first requester above the last owner wins.
    always_comb begin
        winner = '0;
        for (int k = master_c; k >= 1; k--) begin
            if (req[rr_idx(last_idx_reg, k)]) winner = rr_idx(last_idx_reg, k);
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            last_idx_reg <= IW'(master_c - 1);
        else if (state_reg == ARB && any_req)
            last_idx_reg <= winner;
    end
`else
    always_comb begin
        winner = '0;
        for (int i = master_c - 1; i >= 0; i--) begin
            if (req[IW'(i)]) winner = IW'(i);
        end
    end
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_reg     <= ARB;
            owner_idx_reg <= '0;
        end else begin
            state_reg     <= state_next;
            owner_idx_reg <= owner_idx_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_idx_next = owner_idx_reg;
        owner          = '0;
        haddr          = '0;
        hwdata         = '0;
        hwrite         = '0;
        htrans         = 2'b00;
        hsize          = '0;
        hburst         = '0;
        if (state_reg == ARB) begin
            if (any_req) begin
                state_next     = OWN;
                owner_idx_next = winner;
            end
        end else begin
            owner[owner_idx_reg] = 1'b1;
            haddr  = haddr_m[owner_idx_reg];
            hwdata = hwdata_m[owner_idx_reg];
            hwrite = hwrite_m[owner_idx_reg];
            htrans = htrans_m[owner_idx_reg];
            hsize  = hsize_m[owner_idx_reg];
            hburst = hburst_m[owner_idx_reg];
            // Release only once the owner is idle and the slave is ready.
            if (hready == 1'b1 && htrans_m[owner_idx_reg] == 2'b00)
                state_next = ARB;
        end
    end
endmodule

// File: tb/tb_nf_ahb_arb.sv
// Scoreboard bench for nf_ahb_arb: expectations queued per cycle, checked after the edge.
`timescale 1ns/1ps
module tb_nf_ahb_arb;
    localparam int MC = 2;

    logic                hclk = 1'b0;
    logic                hresetn;
    logic [MC-1:0][31:0] haddr_m, hwdata_m;
    logic [MC-1:0][0:0]  hwrite_m;
    logic [MC-1:0][1:0]  htrans_m;
    logic [MC-1:0][2:0]  hsize_m, hburst_m;
    logic [MC-1:0][31:0] hrdata_m;
    logic [MC-1:0][1:0]  hresp_m;
    logic [MC-1:0][0:0]  hready_m;
    logic [31:0]         haddr, hwdata, hrdata;
    logic [0:0]          hwrite, hready;
    logic [1:0]          htrans, hresp;
    logic [2:0]          hsize, hburst;
    logic [MC-1:0]       owner;

    nf_ahb_arb #(.master_c(MC)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .haddr_m(haddr_m), .hwdata_m(hwdata_m), .hwrite_m(hwrite_m),
        .htrans_m(htrans_m), .hsize_m(hsize_m), .hburst_m(hburst_m),
        .hrdata_m(hrdata_m), .hresp_m(hresp_m), .hready_m(hready_m),
        .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .htrans(htrans),
        .hsize(hsize), .hburst(hburst),
        .hrdata(hrdata), .hresp(hresp), .hready(hready),
        .owner(owner)
    );

    always #5 hclk = ~hclk;

    localparam int S_OWNER = 0, S_HADDR = 1, S_HTRANS = 2, S_HWRITE = 3, S_HWDATA = 4,
                   S_HBURST = 5, S_HSIZE = 6, S_HREADY_M = 7, S_HRESP_M = 8,
                   S_HRDATA0 = 9, S_HRDATA1 = 10;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_OWNER:    return 32'(owner);
            S_HADDR:    return haddr;
            S_HTRANS:   return 32'(htrans);
            S_HWRITE:   return 32'(hwrite);
            S_HWDATA:   return hwdata;
            S_HBURST:   return 32'(hburst);
            S_HSIZE:    return 32'(hsize);
            S_HREADY_M: return 32'(hready_m);
            S_HRESP_M:  return 32'(hresp_m);
            S_HRDATA0:  return hrdata_m[0];
            S_HRDATA1:  return hrdata_m[1];
            default:    return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic expect_sig(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(e.tag, observe(e.sig), e.val);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
        cyc++;
        $display("cyc %0d rst_n=%b owner=%b htrans=%0d haddr=%08h hready_m=%b hresp_m=%b",
                 cyc, hresetn, owner, htrans, haddr, hready_m, hresp_m);
        drain();
    endtask

    task automatic set_m(input int i, input logic [1:0] tr, input logic [31:0] a,
                         input logic wr, input logic [31:0] wd, input logic [2:0] burst);
        htrans_m[i] = tr;
        haddr_m[i]  = a;
        hwrite_m[i] = wr;
        hwdata_m[i] = wd;
        hburst_m[i] = burst;
        hsize_m[i]  = 3'd2;
    endtask

    task automatic idle_all();
        for (int i = 0; i < MC; i++) set_m(i, 2'b00, 32'h0, 1'b0, 32'h0, 3'd0);
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        idle_all();
        tick();
        hresetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        hresetn = 1'b0;
        hready  = 1'b1;
        hresp   = 2'b00;
        hrdata  = 32'h1234_5678;
        idle_all();
        tick();
        // Reset state
        expect_sig("rst_owner", S_OWNER, 32'h0);
        expect_sig("rst_htrans", S_HTRANS, 32'h0);
        expect_sig("rst_haddr", S_HADDR, 32'h0);
        expect_sig("rst_hready_m", S_HREADY_M, 32'h0);
        expect_sig("rst_hresp_m", S_HRESP_M, 32'h0);
        expect_sig("rst_hrdata0", S_HRDATA0, 32'h1234_5678);
        expect_sig("rst_hrdata1", S_HRDATA1, 32'h1234_5678);
        tick();
        hresetn = 1'b1;

        // Single read by master 0
        set_m(0, 2'b10, 32'h0000_0010, 1'b0, 32'h0, 3'd0);
        hrdata = 32'hCAFE_0010;
        expect_sig("rd_owner", S_OWNER, 32'h1);
        expect_sig("rd_haddr", S_HADDR, 32'h10);
        expect_sig("rd_htrans", S_HTRANS, 32'h2);
        expect_sig("rd_hready_m", S_HREADY_M, 32'h1);
        expect_sig("rd_hrdata0", S_HRDATA0, 32'hCAFE_0010);
        expect_sig("rd_hrdata1", S_HRDATA1, 32'hCAFE_0010);
        tick();
        set_m(0, 2'b00, 32'h0, 1'b0, 32'h0, 3'd0);
        expect_sig("rd_rel_owner", S_OWNER, 32'h0);
        expect_sig("rd_rel_htrans", S_HTRANS, 32'h0);
        expect_sig("rd_rel_haddr", S_HADDR, 32'h0);
        tick();

        // Simultaneous requests after reset
        do_reset();
        set_m(0, 2'b10, 32'h100, 1'b0, 32'h0, 3'd0);
        set_m(1, 2'b10, 32'h200, 1'b0, 32'h0, 3'd0);
        expect_sig("sim_owner", S_OWNER, 32'h1);
        expect_sig("sim_haddr", S_HADDR, 32'h100);
        expect_sig("sim_hready_m", S_HREADY_M, 32'h1);
        tick();
        set_m(0, 2'b00, 32'h0, 1'b0, 32'h0, 3'd0);
        expect_sig("sim_arb_owner", S_OWNER, 32'h0);
        expect_sig("sim_arb_hready_m", S_HREADY_M, 32'h0);
        tick();
        set_m(0, 2'b10, 32'h104, 1'b0, 32'h0, 3'd0);
`ifdef NF_AHB_ARB_RR_EN
        expect_sig("sim2_owner", S_OWNER, 32'h2);
        expect_sig("sim2_haddr", S_HADDR, 32'h200);
        expect_sig("sim2_hready_m", S_HREADY_M, 32'h2);
`else
        expect_sig("sim2_owner", S_OWNER, 32'h1);
        expect_sig("sim2_haddr", S_HADDR, 32'h104);
        expect_sig("sim2_hready_m", S_HREADY_M, 32'h1);
`endif
        tick();
`ifdef NF_AHB_ARB_RR_EN
        set_m(1, 2'b00, 32'h0, 1'b0, 32'h0, 3'd0);
`else
        set_m(0, 2'b00, 32'h0, 1'b0, 32'h0, 3'd0);
`endif
        expect_sig("sim2_arb_owner", S_OWNER, 32'h0);
        tick();
`ifdef NF_AHB_ARB_RR_EN
        set_m(1, 2'b10, 32'h204, 1'b0, 32'h0, 3'd0);
        expect_sig("sim3_haddr", S_HADDR, 32'h104);
`else
        set_m(0, 2'b10, 32'h108, 1'b0, 32'h0, 3'd0);
        expect_sig("sim3_haddr", S_HADDR, 32'h108);
`endif
        expect_sig("sim3_owner", S_OWNER, 32'h1);
        expect_sig("sim3_hready_m", S_HREADY_M, 32'h1);
        tick();
        idle_all();
        expect_sig("sim_end_owner", S_OWNER, 32'h0);
        tick();

        // Owner goes idle while the slave stalls
        set_m(0, 2'b10, 32'h20, 1'b0, 32'h0, 3'd0);
        expect_sig("stall_grant", S_OWNER, 32'h1);
        tick();
        set_m(0, 2'b00, 32'h0, 1'b0, 32'h0, 3'd0);
        set_m(1, 2'b10, 32'h300, 1'b0, 32'h0, 3'd0);
        hready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            expect_sig($sformatf("stall_owner%0d", n), S_OWNER, 32'h1);
            expect_sig($sformatf("stall_hready_m%0d", n), S_HREADY_M, 32'h0);
            tick();
        end
        hready = 1'b1;
        set_m(1, 2'b00, 32'h0, 1'b0, 32'h0, 3'd0);
        expect_sig("stall_rel_owner", S_OWNER, 32'h0);
        tick();
        expect_sig("dropped_req_owner", S_OWNER, 32'h0);
        tick();

        // Two-cycle ERROR response to master 1
        set_m(1, 2'b10, 32'h400, 1'b0, 32'h0, 3'd0);
        expect_sig("err_grant", S_OWNER, 32'h2);
        expect_sig("err_haddr", S_HADDR, 32'h400);
        tick();
        hready = 1'b0;
        hresp  = 2'b01;
        expect_sig("err1_owner", S_OWNER, 32'h2);
        expect_sig("err1_hresp_m", S_HRESP_M, 32'h4);
        expect_sig("err1_hready_m", S_HREADY_M, 32'h0);
        tick();
        hready = 1'b1;
        expect_sig("err2_owner", S_OWNER, 32'h2);
        expect_sig("err2_hresp_m", S_HRESP_M, 32'h4);
        expect_sig("err2_hready_m", S_HREADY_M, 32'h2);
        tick();
        hresp = 2'b00;
        set_m(1, 2'b00, 32'h0, 1'b0, 32'h0, 3'd0);
        expect_sig("err_rel_owner", S_OWNER, 32'h0);
        expect_sig("err_rel_hresp_m", S_HRESP_M, 32'h0);
        tick();

        // Reset in the middle of a write burst
        set_m(1, 2'b10, 32'h500, 1'b1, 32'hDEAD_0001, 3'b011);
        expect_sig("wb_owner", S_OWNER, 32'h2);
        expect_sig("wb_haddr", S_HADDR, 32'h500);
        expect_sig("wb_hwrite", S_HWRITE, 32'h1);
        expect_sig("wb_hwdata", S_HWDATA, 32'hDEAD_0001);
        expect_sig("wb_hburst", S_HBURST, 32'h3);
        expect_sig("wb_hsize", S_HSIZE, 32'h2);
        tick();
        set_m(1, 2'b11, 32'h504, 1'b1, 32'hDEAD_0002, 3'b011);
        expect_sig("wb_seq_htrans", S_HTRANS, 32'h3);
        expect_sig("wb_seq_haddr", S_HADDR, 32'h504);
        expect_sig("wb_seq_hwdata", S_HWDATA, 32'hDEAD_0002);
        tick();
        set_m(0, 2'b10, 32'h600, 1'b0, 32'h0, 3'd0);
        hresetn = 1'b0;
        #1;
        expect_sig("arst_htrans", S_HTRANS, 32'h0);
        expect_sig("arst_owner", S_OWNER, 32'h0);
        expect_sig("arst_haddr", S_HADDR, 32'h0);
        expect_sig("arst_hwrite", S_HWRITE, 32'h0);
        expect_sig("arst_hready_m", S_HREADY_M, 32'h0);
        drain();
        tick();
        hresetn = 1'b1;
        expect_sig("post_rst_owner", S_OWNER, 32'h1);
        expect_sig("post_rst_haddr", S_HADDR, 32'h600);
        expect_sig("post_rst_htrans", S_HTRANS, 32'h2);
        tick();
        idle_all();
        expect_sig("final_owner", S_OWNER, 32'h0);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/nf_ahb_arb.md
NF_AHB_ARB -- requirements
Module: nf_ahb_arb

Interface
REQ-001 The block SHALL expose parameter master_c, default 2, meaning the number of AHB-Lite masters sharing one bus (range 2..8).
REQ-002 The block SHALL have port hclk, input, 1, the single clock.
REQ-003 The block SHALL have port hresetn, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port haddr_m, input, [master_c-1:0][31:0], per-master HADDR.
REQ-005 The block SHALL have port hwdata_m, input, [master_c-1:0][31:0], per-master HWDATA.
REQ-006 The block SHALL have port hwrite_m, input, [master_c-1:0][0:0], per-master HWRITE.
REQ-007 The block SHALL have port htrans_m, input, [master_c-1:0][1:0], per-master HTRANS.
REQ-008 The block SHALL have port hsize_m, input, [master_c-1:0][2:0], per-master HSIZE.
REQ-009 The block SHALL have port hburst_m, input, [master_c-1:0][2:0], per-master HBURST.
REQ-010 The block SHALL have port hrdata_m, output, [master_c-1:0][31:0], per-master HRDATA.
REQ-011 The block SHALL have port hresp_m, output, [master_c-1:0][1:0], per-master HRESP.
REQ-012 The block SHALL have port hready_m, output, [master_c-1:0][0:0], per-master HREADY.
REQ-013 The block SHALL have outputs haddr[31:0], hwdata[31:0], hwrite[0:0], htrans[1:0], hsize[2:0], hburst[2:0], driving the shared bus toward the router.
REQ-014 The block SHALL have inputs hrdata[31:0], hresp[1:0], hready[0:0], returned from the router.
REQ-015 The block SHALL have port owner, output, [master_c-1:0], one-hot current bus owner (all zero when no owner).

Function
REQ-016 Master i SHALL request the bus whenever htrans_m[i] != 2'b00 (IDLE); BUSY counts as a request.
REQ-017 FSM states SHALL be ARB (no owner) and OWN (one owner).
REQ-018 In ARB: bus outputs SHALL be htrans=IDLE, haddr=0, other controls 0, hready_m all 0, hresp_m all OKAY.
REQ-019 ARB->OWN SHALL occur on the first clock edge with any request; winner registered in owner_idx; one-cycle arbitration latency.
REQ-020 In OWN: all bus outputs, including hwdata, SHALL be the owner's signals; hready_m[owner]=hready; hresp_m[owner]=hresp.
REQ-021 In OWN: non-owners SHALL see hready_m=0 and hresp_m=OKAY, so they hold their address phase stalled.
REQ-022 hrdata_m[i] SHALL equal hrdata for all i in all states.
REQ-023 OWN->ARB SHALL occur only on an edge where hready=1 and htrans_m[owner]=IDLE; no data phase is then outstanding.
REQ-024 Ownership SHALL never change while hready=0, including a two-cycle ERROR response.
REQ-025 Winner selection SHALL be round-robin: first requester at index above last owner, wrapping modulo master_c.
REQ-026 Simultaneous requests SHALL grant exactly one master; others SHALL remain stalled until a later ARB cycle.
REQ-027 A master dropping its request while in ARB SHALL not be granted.

Reset
REQ-028 On hresetn=0, state SHALL become ARB asynchronously and owner SHALL become 0.
REQ-029 On hresetn=0, the last-owner pointer SHALL become master_c-1, so master 0 wins first.
REQ-030 Reset during OWN SHALL abandon the transfer; all outputs SHALL take their ARB values immediately.

Configuration
REQ-031 With macro NF_AHB_ARB_RR_EN defined, selection SHALL be round-robin per REQ-025.
REQ-032 Without NF_AHB_ARB_RR_EN, selection SHALL be fixed priority (lowest index wins), and the last-owner pointer SHALL be omitted.

Verification
REQ-033 Reset, then master 0 NONSEQ read at 0x0000_0010 -> owner=01 next cycle; haddr=0x10 during OWN; hrdata_m[0] = slave data when hready=1.
REQ-034 Masters 0 and 1 request in the same cycle with RR enabled -> master 0 wins; after it goes IDLE -> ARB cycle, then master 1 wins; hready_m[1]=0 until then.
REQ-035 Owner issues IDLE while slave holds hready=0 for 3 cycles -> owner unchanged until the hready=1 edge, then ARB.
REQ-036 Slave ERROR response (hresp=01 with hready 0 then 1) -> hresp_m[owner]=01 on both cycles; non-owner hresp_m=00; owner held.
REQ-037 Reset asserted mid write burst -> htrans=IDLE and owner=0 immediately; first post-reset grant goes to master 0.
REQ-038 Without NF_AHB_ARB_RR_EN, master 0 re-requests on every ARB cycle -> master 0 always wins and master 1 stays stalled.
